// File: rtl/ring_mod_multi_if.sv
// ring_mod_multi_if: start/ready request and registered result bus of ring_mod_multi.
interface ring_mod_multi_if #(
    parameter int IN_WIDTH  = 20,
    parameter int OUT_WIDTH = 16,
    parameter int CHANNELS  = 2
);
    logic [CHANNELS*IN_WIDTH-1:0]  i_Sample1;
    logic [CHANNELS*IN_WIDTH-1:0]  i_Sample2;
    logic [1:0]                    i_Mode;
    logic                          i_Start;
    logic [CHANNELS*OUT_WIDTH-1:0] o_Result;
    logic                          o_Ready;
    logic                          o_Valid;
    modport master (output i_Sample1, i_Sample2, i_Mode, i_Start, input o_Result, o_Ready, o_Valid);
    modport slave (input i_Sample1, i_Sample2, i_Mode, i_Start, output o_Result, o_Ready, o_Valid);
endinterface

// File: rtl/ring_mod_multi.sv
// ring_mod_multi: multi-channel ring/AM/bypass/mix modulator sharing one multiplier,
// processing channels sequentially through CLAMP/MULT/SHIFT/SAT with symmetric saturation.
module ring_mod_multi #(
    parameter int IN_WIDTH  = 20,
    parameter int OUT_WIDTH = 16,
    parameter int CHANNELS  = 2,
    parameter int SHIFT     = 11,
    parameter int SAT       = 32767
) (
    input logic i_Clock,
    input logic i_Reset,
    ring_mod_multi_if.slave bus
);
    localparam int PW = 2*OUT_WIDTH + 2;
    localparam int KW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam logic signed [PW-1:0] SATW = PW'(SAT);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLAMP = 3'd1;
    localparam logic [2:0] ST_MULT  = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_SAT   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic [2:0]                    state_q, state_d;
    logic [KW-1:0]                 k_q, k_d;
    logic [CHANNELS*IN_WIDTH-1:0]  s1_q, s1_d, s2_q, s2_d;
    logic [1:0]                    mode_q, mode_d;
    logic signed [PW-1:0]          a_q, a_d, b_q, b_d, acc_q, acc_d, aw, bw;
    logic [CHANNELS*OUT_WIDTH-1:0] rbuf_q, rbuf_d, res_q, res_d;
    logic                          ready_q, ready_d, valid_q, valid_d, last;

    function automatic logic signed [PW-1:0] clamp(input logic signed [PW-1:0] x);
        return x > SATW ? SATW : (x < -SATW ? -SATW : x);
    endfunction

    always_comb begin
        aw      = PW'($signed(s1_q[k_q*IN_WIDTH +: IN_WIDTH]));
        bw      = PW'($signed(s2_q[k_q*IN_WIDTH +: IN_WIDTH]));
        last    = k_q == KW'(CHANNELS-1);
        state_d = state_q;
        k_d     = k_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        mode_d  = mode_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        rbuf_d  = rbuf_q;
        res_d   = res_q;
        ready_d = ready_q;
        valid_d = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.i_Start) begin
                s1_d    = bus.i_Sample1;
                s2_d    = bus.i_Sample2;
                mode_d  = bus.i_Mode;
                ready_d = 1'b0;
                state_d = ST_CLAMP;
            end
            ST_CLAMP: begin
                a_d     = clamp(aw);
                b_d     = clamp(bw);
                state_d = ST_MULT;
            end
            ST_MULT: begin
                // AM offsets the modulator to the unipolar range 0..2*SAT
                acc_d   = mode_q == 2'd0 ? a_q * b_q :
                          mode_q == 2'd1 ? a_q * (b_q + SATW) :
                          mode_q == 2'd2 ? a_q : a_q + b_q;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                acc_d   = acc_q >>> (mode_q == 2'd0 ? SHIFT : mode_q == 2'd1 ? SHIFT + 1 :
                                     mode_q == 2'd2 ? 0 : 1);
                state_d = ST_SAT;
            end
            ST_SAT: begin
                rbuf_d[k_q*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(clamp(acc_q));
                k_d     = last ? '0 : k_q + 1'b1;
                state_d = last ? ST_DONE : ST_CLAMP;
            end
            ST_DONE: begin
                res_d   = rbuf_q;
                valid_d = 1'b1;
                ready_d = 1'b1;
                k_d     = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            mode_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            rbuf_q  <= '0;
            res_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            mode_q  <= mode_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            rbuf_q  <= rbuf_d;
            res_q   <= res_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign bus.o_Result = res_q;
    assign bus.o_Ready  = ready_q;
    assign bus.o_Valid  = valid_q;
endmodule

// File: tb/tb_ring_mod_multi.sv
// tb_ring_mod_multi: directed vector table plus handshake, back-to-back and
// mid-operation reset sequences for ring_mod_multi.
module tb_ring_mod_multi;
    localparam int IW = 20;
    localparam int OW = 16;
    localparam int CH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    ring_mod_multi_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CHANNELS(CH)) bus ();
    ring_mod_multi #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CHANNELS(CH), .SHIFT(11), .SAT(32767))
        dut (.i_Clock(clk), .i_Reset(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        int a0, b0, a1, b1, r0, r1;
    } vec_t;
    vec_t v[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int res(input int k);
        logic signed [OW-1:0] r;
        r = bus.o_Result[k*OW +: OW];
        return int'(r);
    endfunction

    task automatic drive(input vec_t x);
        bus.i_Mode    = x.mode;
        bus.i_Sample1 = {IW'(x.a1), IW'(x.a0)};
        bus.i_Sample2 = {IW'(x.b1), IW'(x.b0)};
    endtask

    task automatic wait_valid(output int n, output int busy_bad);
        n = 0;
        busy_bad = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (!bus.o_Valid && bus.o_Ready) busy_bad++;
        end while (!bus.o_Valid && n < 40);
    endtask

    task automatic run_vec(input vec_t x, input string tag);
        int n, bb;
        @(negedge clk);
        drive(x);
        bus.i_Start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_Start = 1'b0;
        chk({tag, " ready_low_after_accept"}, int'(bus.o_Ready), 0);
        wait_valid(n, bb);
        chk({tag, " latency"}, n, 9);
        chk({tag, " ready_high_while_busy"}, bb, 0);
        chk({tag, " ready_in_valid_cycle"}, int'(bus.o_Ready), 1);
        chk({tag, " ch0"}, res(0), x.r0);
        chk({tag, " ch1"}, res(1), x.r1);
        @(posedge clk);
        #1;
        chk({tag, " valid_one_cycle"}, int'(bus.o_Valid), 0);
        chk({tag, " result_hold"}, res(0), x.r0);
    endtask

    initial begin
        int n, bb;
        vec_t alt;
        v[0] = '{2'd0, 1000, 2000, -1000, 2000, 976, -977};
        v[1] = '{2'd0, 100000, 32767, -100000, 32767, 32767, -32767};
        v[2] = '{2'd0, -32768, -32768, 0, 5, 32767, 0};
        v[3] = '{2'd1, 1000, -32767, 1000, 32767, 0, 15999};
        v[4] = '{2'd3, 1000, -3001, -1, 0, -1001, -1};
        v[5] = '{2'd2, -40000, 123, 500, -9, -32767, 500};
        v[6] = '{2'd0, -1, 1, 2048, 1, -1, 1};
        v[7] = '{2'd1, -1000, 32767, 32767, 32767, -16000, 32767};
        alt = '{2'd3, 40000, 40000, 7, 9, 32767, 8};
        bus.i_Start = 1'b0;
        drive(v[0]);
        #12;
        chk("reset result", int'(bus.o_Result), 0);
        chk("reset ready", int'(bus.o_Ready), 1);
        chk("reset valid", int'(bus.o_Valid), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) run_vec(v[i], $sformatf("vec%0d", i));
        run_vec(alt, "mix_sat");
        // inputs and i_Start wiggle while busy; result must reflect the captured request
        @(negedge clk);
        drive(v[0]);
        bus.i_Start = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        do begin
            drive(alt);
            bus.i_Start = n < 7;
            @(posedge clk);
            #1;
            n++;
        end while (!bus.o_Valid && n < 40);
        bus.i_Start = 1'b0;
        chk("busy_change latency", n, 9);
        chk("busy_change ch0", res(0), 976);
        chk("busy_change ch1", res(1), -977);
        @(posedge clk);
        #1;
        chk("busy_change idle_after", int'(bus.o_Ready), 1);
        // i_Start held high: results every 10 edges
        @(negedge clk);
        drive(v[3]);
        bus.i_Start = 1'b1;
        wait_valid(n, bb);
        chk("b2b first ch1", res(1), 15999);
        drive(v[4]);
        wait_valid(n, bb);
        bus.i_Start = 1'b0;
        chk("b2b period", n, 10);
        chk("b2b second ch0", res(0), -1001);
        @(posedge clk);
        #1;
        chk("b2b stop ready", int'(bus.o_Ready), 1);
        // asynchronous reset during MULT of channel 1
        @(negedge clk);
        drive(v[0]);
        bus.i_Start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_Start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midreset result", int'(bus.o_Result), 0);
        chk("midreset ready", int'(bus.o_Ready), 1);
        chk("midreset valid", int'(bus.o_Valid), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.o_Valid) bb = -1;
        end
        chk("midreset no_stale_valid", bb == -1 ? 1 : 0, 0);
        run_vec(v[1], "after_reset");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
